mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  RV32I pipeline MEM stage, directly upstream of write-back. Takes the EX/MEM
//  bundle, drives the data-memory port (read/write, byte mask, lane-aligned
//  store data), stalls the pipe until dmem_resp, and registers the MEM/WB
//  bundle (ctrl, alu_out, br_en, u_imm, pc, rd, raw mdr word, rmask) consumed
//  by write-back's load extract/extend muxing.
// PARAMETERS
//  XLEN      32  datapath width; only 32 supported
//  CNT_W     32  perf counter width (used only with MEM_PERF_CNT_EN)
// PORTS
//  clk           in   1     single clock, all flops on posedge
//  rst           in   1     synchronous, active-high
//  ex_valid      in   1     EX/MEM bundle holds a real instruction
//  ex_ctrl       in   ctrl  rv32i_control_word (opcode, funct3, mem_read/write, load_regfile, regfilemux_sel)
//  ex_alu_out    in   32    effective address / ALU result
//  ex_rs2_out    in   32    store data
//  ex_br_en      in   1     compare result
//  ex_u_imm      in   32    U-immediate
//  ex_pc         in   32    instruction PC
//  ex_rd         in   5     destination register
//  dmem_address  out  32    {ex_alu_out[31:2],2'b00}
//  dmem_read     out  1     load request
//  dmem_write    out  1     store request
//  dmem_wmask    out  4     byte enables for store
//  dmem_wdata    out  32    lane-shifted store data
//  dmem_rdata    in   32    read data, valid with dmem_resp
//  dmem_resp     in   1     one-cycle completion pulse
//  mem_stall     out  1     freeze IF/ID/EX and EX/MEM register
//  wb_valid/wb_ctrl/wb_alu_out/wb_br_en/wb_u_imm/wb_pc/wb_rd  out  MEM/WB copies
//  wb_mdr        out  32    captured dmem_rdata (unextended)
//  wb_rmask      out  4     load byte lanes
// BEHAVIOUR
//  - FSM mem_state_t {IDLE, BUSY}. mem_op = ex_valid & (mem_read|mem_write).
//  - IDLE: mem_op -> drive dmem_read/write comb.; resp same cycle -> stay IDLE,
//    else -> BUSY. BUSY: hold address/mask/data/request stable; resp -> IDLE.
//  - mem_stall = mem_op & ~dmem_resp (comb., both states). Zero-wait mem = no stall.
//  - Masks by funct3, a=addr[1:0]: B: 4'b0001<<a; H: 4'b0011<<{a[1],1'b0};
//    W: 4'b1111 (low addr bits ignored, no trap). rmask same rule on loads,
//    0 otherwise; dmem_wmask 0 unless dmem_write.
//  - wdata: SB {4{rs2[7:0]}}; SH {2{rs2[15:0]}}; SW rs2 (mask selects lanes).
//  - MEM/WB reg, posedge: rst -> all wb_* 0 (wb_valid=0, wb_ctrl zeroed so
//    load_regfile=0). mem_stall -> wb_valid<=0, wb_ctrl.load_regfile<=0 (bubble),
//    other fields don't-care. Else copy ex_*; wb_mdr<=dmem_rdata on loads.
//  - Latency: non-memory ops 1 cycle; memory ops 1 cycle after dmem_resp.
//  - dmem_resp in IDLE with no mem_op: ignored. ex_valid=0: no request, wb_valid=0.
//  - rst in BUSY: state->IDLE; request deasserts only if ex_valid drops (upstream
//    also reset); no stale resp captured.
//  - Outputs at reset: dmem_read/write=0 when ex_valid=0; mem_stall=0; all wb_* 0.
// CONFIGURATION
//  MEM_PERF_CNT_EN defined: adds outputs perf_loads, perf_stores, perf_stall_cyc
//  (CNT_W each, wrap on overflow, cleared by rst); ++ on load/store retire
//  (dmem_resp with mem_op) and each mem_stall=1 cycle. Undefined: ports and
//  counters absent; other behaviour identical.
// STRUCTURE
//  - rv32i_types package: mem_state_t enum; reuse load/store funct3 enums,
//    rv32i_control_word. No new localparams outside the package.
//  - Sub-module mem_mask_gen (comb.): funct3, addr[1:0], rs2, rd/wr ->
//    rmask, wmask, wdata. FSM and MEM/WB reg stay in mem_stage.
// TESTING
//  1 SW addr 0x100, rs2 0xDEADBEEF, resp at cycle 3 -> wmask 1111, wdata DEADBEEF,
//    mem_stall=1 cycles 0-2, wb_valid=1 cycle 4 only.
//  2 SB addr 0x103, rs2 0x000000A5 -> dmem_address 0x100, wmask 1000, wdata A5A5A5A5.
//  3 LH addr 0x202, rdata 0x8001_7FFF, resp same cycle -> no stall, wb_rmask 1100,
//    wb_mdr 0x80017FFF next cycle.
//  4 ADD (no mem op), ex_alu_out 0x42 -> no dmem req, wb_alu_out 0x42 next cycle.
//  5 LW in BUSY, rst asserted 1 cycle, resp arrives later -> state IDLE, wb_valid 0,
//    resp ignored.
//  6 MEM_PERF_CNT_EN: 2 loads (3-cycle waits) + 1 store (0-wait) ->
//    perf_loads 2, perf_stores 1, perf_stall_cyc 4.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared RV32I types for the MEM stage: opcode/funct3 encodings, the control
// word carried down the pipe, and the MEM-stage handshake state.
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [3:0] {
    rf_alu_out  = 4'd0,
    rf_br_en    = 4'd1,
    rf_u_imm    = 4'd2,
    rf_lw       = 4'd3,
    rf_pc_plus4 = 4'd4,
    rf_lb       = 4'd5,
    rf_lbu      = 4'd6,
    rf_lh       = 4'd7,
    rf_lhu      = 4'd8
  } regfilemux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    logic [2:0]      funct3;
    logic            mem_read;
    logic            mem_write;
    logic            load_regfile;
    regfilemux_sel_t regfilemux_sel;
  } rv32i_control_word;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_mask_gen.sv
// Byte-lane mask and store-data replication for the data-memory port.
// Purely combinational; the access size comes from funct3[1:0].
module mem_mask_gen
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  input  logic        rd,
  input  logic        wr,
  output logic [3:0]  rmask,
  output logic [3:0]  wmask,
  output logic [31:0] wdata
);

  logic [3:0] lane_mask;

  // Load and store encodings share the size bits, so the unsigned loads
  // fold onto the signed cases once bit 2 is dropped.
  always_comb begin
    lane_mask = 4'b1111;
    wdata     = rs2;
    unique case (store_funct3_t'({1'b0, funct3[1:0]}))
      sb: begin
        lane_mask = 4'b0001 << addr;
        wdata     = {4{rs2[7:0]}};
      end
      sh: begin
        lane_mask = 4'b0011 << {addr[1], 1'b0};
        wdata     = {2{rs2[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        wdata     = rs2;
      end
    endcase
  end

  assign rmask = rd ? lane_mask : 4'b0000;
  assign wmask = wr ? lane_mask : 4'b0000;

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: drives the data-memory port, stalls until dmem_resp and
// registers the MEM/WB bundle. Optional counters under MEM_PERF_CNT_EN.
module mem_stage
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  input  rv32i_control_word       ex_ctrl,
  input  logic [XLEN-1:0]         ex_alu_out,
  input  logic [XLEN-1:0]         ex_rs2_out,
  input  logic                    ex_br_en,
  input  logic [XLEN-1:0]         ex_u_imm,
  input  logic [XLEN-1:0]         ex_pc,
  input  logic [4:0]              ex_rd,
  output logic [XLEN-1:0]         dmem_address,
  output logic                    dmem_read,
  output logic                    dmem_write,
  output logic [3:0]              dmem_wmask,
  output logic [XLEN-1:0]         dmem_wdata,
  input  logic [XLEN-1:0]         dmem_rdata,
  input  logic                    dmem_resp,
  output logic                    mem_stall,
  output logic                    wb_valid,
  output rv32i_control_word       wb_ctrl,
  output logic [XLEN-1:0]         wb_alu_out,
  output logic                    wb_br_en,
  output logic [XLEN-1:0]         wb_u_imm,
  output logic [XLEN-1:0]         wb_pc,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_mdr,
  output logic [3:0]              wb_rmask
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]        perf_loads,
  output logic [CNT_W-1:0]        perf_stores,
  output logic [CNT_W-1:0]        perf_stall_cyc
`endif
);

  if (XLEN != 32 || CNT_W < 1) begin : g_bad_param
    $error("mem_stage supports only XLEN=32 and CNT_W>=1");
  end

  mem_state_t state, state_next;
  logic       mem_op;
  logic [3:0] rmask;

  assign mem_op = ex_valid & (ex_ctrl.mem_read | ex_ctrl.mem_write);

  mem_mask_gen u_mask_gen (
    .funct3 (ex_ctrl.funct3),
    .addr   (ex_alu_out[1:0]),
    .rs2    (ex_rs2_out),
    .rd     (dmem_read),
    .wr     (dmem_write),
    .rmask  (rmask),
    .wmask  (dmem_wmask),
    .wdata  (dmem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (mem_op && !dmem_resp) state_next = BUSY;
      BUSY: if (dmem_resp || !mem_op) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request stays asserted in BUSY simply because the stalled EX/MEM
  // register keeps presenting the same bundle.
  always_comb begin
    dmem_address = {ex_alu_out[XLEN-1:2], 2'b00};
    dmem_read    = ex_valid & ex_ctrl.mem_read;
    dmem_write   = ex_valid & ex_ctrl.mem_write;
    mem_stall    = mem_op & ~dmem_resp;
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_ctrl    <= '0;
      wb_alu_out <= '0;
      wb_br_en   <= 1'b0;
      wb_u_imm   <= '0;
      wb_pc      <= '0;
      wb_rd      <= '0;
      wb_mdr     <= '0;
      wb_rmask   <= '0;
    end else begin
      wb_valid   <= ex_valid & ~mem_stall;
      wb_ctrl    <= ex_ctrl;
      wb_alu_out <= ex_alu_out;
      wb_br_en   <= ex_br_en;
      wb_u_imm   <= ex_u_imm;
      wb_pc      <= ex_pc;
      wb_rd      <= ex_rd;
      wb_rmask   <= rmask;
      if (mem_stall || !ex_valid) wb_ctrl.load_regfile <= 1'b0;
      if (dmem_read && !mem_stall) wb_mdr <= dmem_rdata;
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads     <= '0;
      perf_stores    <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (dmem_read && dmem_resp)  perf_loads     <= perf_loads + 1'b1;
      if (dmem_write && dmem_resp) perf_stores    <= perf_stores + 1'b1;
      if (mem_stall)               perf_stall_cyc <= perf_stall_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus wait-state,
// reset-in-BUSY and (with MEM_PERF_CNT_EN) counter sequences.
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid;
  rv32i_control_word ex_ctrl;
  logic [31:0]       ex_alu_out, ex_rs2_out, ex_u_imm, ex_pc;
  logic              ex_br_en;
  logic [4:0]        ex_rd;
  logic [31:0]       dmem_address, dmem_wdata, dmem_rdata;
  logic              dmem_read, dmem_write, dmem_resp, mem_stall;
  logic [3:0]        dmem_wmask, wb_rmask;
  logic              wb_valid, wb_br_en;
  rv32i_control_word wb_ctrl;
  logic [31:0]       wb_alu_out, wb_u_imm, wb_pc, wb_mdr;
  logic [4:0]        wb_rd;
`ifdef MEM_PERF_CNT_EN
  logic [31:0]       perf_loads, perf_stores, perf_stall_cyc;
`endif

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_alu_out(ex_alu_out), .ex_rs2_out(ex_rs2_out), .ex_br_en(ex_br_en),
    .ex_u_imm(ex_u_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .mem_stall(mem_stall), .wb_valid(wb_valid),
    .wb_ctrl(wb_ctrl), .wb_alu_out(wb_alu_out), .wb_br_en(wb_br_en),
    .wb_u_imm(wb_u_imm), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_mdr(wb_mdr),
    .wb_rmask(wb_rmask)
`ifdef MEM_PERF_CNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores),
    .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              valid;
    rv32i_control_word ctrl;
    logic [31:0]       addr;
    logic [31:0]       rs2;
    logic [31:0]       rdata;
    logic              resp;
    logic              e_rd;
    logic              e_wr;
    logic [3:0]        e_wmask;
    logic [31:0]       e_wdata;
    logic              e_stall;
    logic              e_wbv;
    logic [3:0]        e_rmask;
    logic [31:0]       e_mdr;
  } vec_t;

  vec_t vecs[8];

  function automatic rv32i_control_word cw_load(input logic [2:0] f3);
    rv32i_control_word c;
    c = '0;
    c.opcode = op_load;
    c.funct3 = f3;
    c.mem_read = 1'b1;
    c.load_regfile = 1'b1;
    c.regfilemux_sel = rf_lw;
    return c;
  endfunction

  function automatic rv32i_control_word cw_store(input logic [2:0] f3);
    rv32i_control_word c;
    c = '0;
    c.opcode = op_store;
    c.funct3 = f3;
    c.mem_write = 1'b1;
    return c;
  endfunction

  function automatic rv32i_control_word cw_alu();
    rv32i_control_word c;
    c = '0;
    c.opcode = op_reg;
    c.load_regfile = 1'b1;
    c.regfilemux_sel = rf_alu_out;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input rv32i_control_word c, input logic [31:0] a,
                       input logic [31:0] r2, input logic [31:0] rdat, input logic rsp);
    ex_valid   = v;
    ex_ctrl    = c;
    ex_alu_out = a;
    ex_rs2_out = r2;
    dmem_rdata = rdat;
    dmem_resp  = rsp;
  endtask

  initial begin
    vecs[0] = '{"sb_lane3", 1'b1, cw_store(sb), 32'h0000_0103, 32'h0000_00A5, 32'h0, 1'b1,
                1'b0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 1'b1, 4'b0000, 32'h0};
    vecs[1] = '{"lh_upper", 1'b1, cw_load(lh), 32'h0000_0202, 32'h0, 32'h8001_7FFF, 1'b1,
                1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 4'b1100, 32'h8001_7FFF};
    vecs[2] = '{"add_nomem", 1'b1, cw_alu(), 32'h0000_0042, 32'h0, 32'h0, 1'b0,
                1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0};
    vecs[3] = '{"sh_upper", 1'b1, cw_store(sh), 32'h0000_0102, 32'h1234_ABCD, 32'h0, 1'b1,
                1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b0, 1'b1, 4'b0000, 32'h0};
    vecs[4] = '{"lb_lane1", 1'b1, cw_load(lbu), 32'h0000_0201, 32'h0, 32'h1122_3344, 1'b1,
                1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 4'b0010, 32'h1122_3344};
    vecs[5] = '{"lw_misalign", 1'b1, cw_load(lw), 32'h0000_0203, 32'h0, 32'hCAFE_F00D, 1'b1,
                1'b1, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D};
    vecs[6] = '{"invalid_ld", 1'b0, cw_load(lw), 32'h0000_0300, 32'h0, 32'h5555_5555, 1'b1,
                1'b0, 1'b0, 4'b0000, 32'h0, 1'b0, 1'b0, 4'b0000, 32'h0};
    vecs[7] = '{"sw_word", 1'b1, cw_store(sw), 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b1,
                1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1, 4'b0000, 32'h0};

    rst = 1'b1;
    ex_br_en = 1'b0; ex_u_imm = 32'h0; ex_pc = 32'h0; ex_rd = 5'd0;
    drive(1'b0, '0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick(); tick();

    // Reset state
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    chk("rst_wb_ctrl", {8'b0, wb_ctrl}, 32'h0);
    chk("rst_wb_mdr", wb_mdr, 32'h0);
    chk("rst_wb_alu", wb_alu_out, 32'h0);
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    chk("rst_req", {30'b0, dmem_read, dmem_write}, 32'h0);
    rst = 1'b0;

    // Zero-wait table
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].valid, vecs[i].ctrl, vecs[i].addr, vecs[i].rs2, vecs[i].rdata, vecs[i].resp);
      ex_pc    = 32'h1000 + 32'(i * 4);
      ex_rd    = 5'(i + 1);
      ex_u_imm = 32'h0ABC_D000 + 32'(i);
      ex_br_en = i[0];
      #1;
      chk({vecs[i].name, "_addr"}, dmem_address, vecs[i].addr & 32'hFFFF_FFFC);
      chk({vecs[i].name, "_rd"}, {31'b0, dmem_read}, {31'b0, vecs[i].e_rd});
      chk({vecs[i].name, "_wr"}, {31'b0, dmem_write}, {31'b0, vecs[i].e_wr});
      chk({vecs[i].name, "_wmask"}, {28'b0, dmem_wmask}, {28'b0, vecs[i].e_wmask});
      if (vecs[i].e_wr) chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].e_wdata);
      chk({vecs[i].name, "_stall"}, {31'b0, mem_stall}, {31'b0, vecs[i].e_stall});
      tick();
      chk({vecs[i].name, "_wbv"}, {31'b0, wb_valid}, {31'b0, vecs[i].e_wbv});
      chk({vecs[i].name, "_ldrf"}, {31'b0, wb_ctrl.load_regfile},
          {31'b0, vecs[i].valid & vecs[i].ctrl.load_regfile});
      chk({vecs[i].name, "_rmask"}, {28'b0, wb_rmask}, {28'b0, vecs[i].e_rmask});
      if (vecs[i].e_wbv) begin
        chk({vecs[i].name, "_alu"}, wb_alu_out, vecs[i].addr);
        chk({vecs[i].name, "_pc"}, wb_pc, 32'h1000 + 32'(i * 4));
        chk({vecs[i].name, "_rdst"}, {27'b0, wb_rd}, 32'(i + 1));
        chk({vecs[i].name, "_uimm"}, wb_u_imm, 32'h0ABC_D000 + 32'(i));
        chk({vecs[i].name, "_bren"}, {31'b0, wb_br_en}, {31'b0, i[0]});
      end
      if (vecs[i].e_rd) chk({vecs[i].name, "_mdr"}, wb_mdr, vecs[i].e_mdr);
    end

    // SW with response in cycle 3
    drive(1'b1, cw_store(sw), 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    #1;
    chk("sw3_c0_stall", {31'b0, mem_stall}, 32'h1);
    chk("sw3_c0_wmask", {28'b0, dmem_wmask}, 32'hF);
    chk("sw3_c0_wdata", dmem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("sw3_c1_stall", {31'b0, mem_stall}, 32'h1);
    chk("sw3_c1_wbv", {31'b0, wb_valid}, 32'h0);
    chk("sw3_c1_busy", {31'b0, dut.state}, {31'b0, BUSY});
    tick();
    chk("sw3_c2_stall", {31'b0, mem_stall}, 32'h1);
    chk("sw3_c2_addr", dmem_address, 32'h0000_0100);
    chk("sw3_c2_wr", {31'b0, dmem_write}, 32'h1);
    tick();
    dmem_resp = 1'b1;
    #1;
    chk("sw3_c3_stall", {31'b0, mem_stall}, 32'h0);
    chk("sw3_c3_wbv", {31'b0, wb_valid}, 32'h0);
    tick();
    drive(1'b0, '0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("sw3_c4_wbv", {31'b0, wb_valid}, 32'h1);
    chk("sw3_c4_idle", {31'b0, dut.state}, {31'b0, IDLE});
    tick();
    chk("sw3_c5_wbv", {31'b0, wb_valid}, 32'h0);

    // LW stuck in BUSY, reset, then a late response
    drive(1'b1, cw_load(lw), 32'h0000_0400, 32'h0, 32'h0, 1'b0);
    tick();
    chk("rbusy_state", {31'b0, dut.state}, {31'b0, BUSY});
    rst = 1'b1;
    drive(1'b0, '0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    chk("rbusy_idle", {31'b0, dut.state}, {31'b0, IDLE});
    chk("rbusy_wbv", {31'b0, wb_valid}, 32'h0);
    dmem_rdata = 32'h7777_7777;
    dmem_resp  = 1'b1;
    #1;
    chk("rbusy_stall", {31'b0, mem_stall}, 32'h0);
    chk("rbusy_req", {31'b0, dmem_read}, 32'h0);
    tick();
    dmem_resp = 1'b0;
    chk("rbusy_late_wbv", {31'b0, wb_valid}, 32'h0);
    chk("rbusy_late_mdr", wb_mdr, 32'h0);
    chk("rbusy_late_idle", {31'b0, dut.state}, {31'b0, IDLE});

`ifdef MEM_PERF_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_clr", perf_loads | perf_stores | perf_stall_cyc, 32'h0);
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, cw_load(lw), 32'h0000_0500, 32'h0, 32'h1234_5678, 1'b0);
      tick();
      tick();
      dmem_resp = 1'b1;
      tick();
      drive(1'b0, '0, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
    end
    drive(1'b1, cw_store(sw), 32'h0000_0600, 32'h0000_0001, 32'h0, 1'b1);
    tick();
    drive(1'b0, '0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    chk("perf_loads", perf_loads, 32'd2);
    chk("perf_stores", perf_stores, 32'd1);
    chk("perf_stall", perf_stall_cyc, 32'd4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
